pc_branch_unit: RTL and testbench

Program-counter and control-transfer stage that consumes the 16-bit sign-extended branch/jump offset produced by the 12→16 sign extender. It owns the fetch PC, drives instruction-memory requests, and computes and applies PC-relative and register-indirect targets. It emits a one-cycle redirect/flush and a link address for jump-and-link. It sits between decode (immediate extraction, sign extension, condition evaluation) and instruction memory.

---
 rtl/pc_branch_unit.sv | 124 ++++++++++++
 tb/tb_pc_branch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Fetch PC owner and control-transfer unit: sequential fetch, PC-relative / register-indirect redirect, jump-and-link.
// Redirect and link pulses are registered (one cycle after the taken edge); stall holds the PC and blocks transfers.
// Optional BRANCH_DELAY_SLOT_EN keeps the word fetched alongside a taken transfer instead of squashing it.
module pc_branch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] PC_INC       = 16'd2,
    parameter int          OFFSET_SHIFT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [15:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    output logic        o_inst_valid,
    input  logic        i_stall,
    input  logic        i_br_valid,
    input  logic [1:0]  i_br_kind,
    input  logic        i_br_cond,
    input  logic [15:0] i_br_base_pc,
    input  logic [15:0] i_br_offset,
    input  logic [15:0] i_br_reg,
    output logic        o_redirect,
    output logic        o_link_valid,
    output logic [15:0] o_link_addr
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] KIND_COND = 2'b00;
    localparam logic [1:0] KIND_JR   = 2'b10;
    localparam logic [1:0] KIND_JAL  = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic        r_redirect;
    logic        r_link_valid;
    logic [15:0] r_link_addr;

    logic        w_taken;
    logic        w_is_jal;
    logic [15:0] w_offset_scaled;
    logic [15:0] w_rel_target;
    logic [15:0] w_reg_target;
    logic [15:0] w_target;
    logic        w_fetch_adv;

    // Transfers are only sampled in FETCH, so a held br_valid cannot retrigger during FLUSH.
    assign w_taken         = (r_state == S_FETCH) && i_br_valid && !i_stall &&
                             ((i_br_kind != KIND_COND) || i_br_cond);
    assign w_is_jal        = (i_br_kind == KIND_JAL);
    assign w_offset_scaled = i_br_offset << OFFSET_SHIFT;
    assign w_rel_target    = i_br_base_pc + w_offset_scaled;
    assign w_reg_target    = {i_br_reg[15:1], 1'b0};
    assign w_target        = (i_br_kind == KIND_JR) ? w_reg_target : w_rel_target;
    assign w_fetch_adv     = (r_state == S_FETCH) && !i_stall && i_imem_ack;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = w_taken ? S_FLUSH : S_FETCH;
            S_FLUSH: w_state_nxt = S_FETCH;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        o_imem_req   = 1'b0;
        o_inst_valid = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_imem_req = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
                o_inst_valid = i_imem_ack && !i_stall;
`else
                o_inst_valid = i_imem_ack && !i_stall && !w_taken;
`endif
            end
            default: begin
                o_imem_req   = 1'b0;
                o_inst_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc         <= RESET_VECTOR;
            r_redirect   <= 1'b0;
            r_link_valid <= 1'b0;
            r_link_addr  <= 16'h0000;
        end else begin
            r_redirect   <= w_taken;
            r_link_valid <= w_taken && w_is_jal;
            if (w_taken) begin
                r_pc <= w_target;
            end else if (w_fetch_adv) begin
                r_pc <= r_pc + PC_INC;
            end
            if (w_taken && w_is_jal) begin
                r_link_addr <= i_br_base_pc + PC_INC;
            end
        end
    end

    assign o_imem_addr  = r_pc;
    assign o_redirect   = r_redirect;
    assign o_link_valid = r_link_valid;
    assign o_link_addr  = r_link_addr;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; expected inst_valid on a taken+ack cycle follows BRANCH_DELAY_SLOT_EN.
module tb_pc_branch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic        inst_valid;
    logic        stall;
    logic        br_valid;
    logic [1:0]  br_kind;
    logic        br_cond;
    logic [15:0] br_base_pc;
    logic [15:0] br_offset;
    logic [15:0] br_reg;
    logic        redirect;
    logic        link_valid;
    logic [15:0] link_addr;

    int errors = 0;
    int checks = 0;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic DS_IV = 1'b1;
`else
    localparam logic DS_IV = 1'b0;
`endif

    pc_branch_unit dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .o_imem_addr  (imem_addr),
        .o_imem_req   (imem_req),
        .i_imem_ack   (imem_ack),
        .o_inst_valid (inst_valid),
        .i_stall      (stall),
        .i_br_valid   (br_valid),
        .i_br_kind    (br_kind),
        .i_br_cond    (br_cond),
        .i_br_base_pc (br_base_pc),
        .i_br_offset  (br_offset),
        .i_br_reg     (br_reg),
        .o_redirect   (redirect),
        .o_link_valid (link_valid),
        .o_link_addr  (link_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (redirect !== 1'b0 || link_valid !== 1'b0) begin errors++; $display("FAIL reset_pulses: got redirect=%b link_valid=%b want 0 0", redirect, link_valid); end
        checks++; if (link_addr !== 16'h0000) begin errors++; $display("FAIL reset_link_addr: got %h want 0000", link_addr); end
    endtask

    task automatic test_seq_fetch();
        logic [15:0] exp_addr [4];
        exp_addr = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        step();
        reset    = 1'b0;
        imem_ack = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", imem_req); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (imem_addr !== exp_addr[i] || imem_req !== 1'b1 || inst_valid !== 1'b1) begin
                errors++; $display("FAIL seq_fetch[%0d]: got addr=%h req=%b iv=%b want addr=%h req=1 iv=1", i, imem_addr, imem_req, inst_valid, exp_addr[i]);
            end
        end
    endtask

    task automatic test_branch_backward();
        repeat (5) step();
        checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL seq_reach_0010: got %h want 0010", imem_addr); end
        br_valid = 1'b1; br_kind = 2'b00; br_cond = 1'b0; br_base_pc = 16'h0010; br_offset = 16'hFFFC;
        #1;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL not_taken_iv: got %b want 1", inst_valid); end
        step();
        checks++; if (imem_addr !== 16'h0012 || redirect !== 1'b0) begin errors++; $display("FAIL not_taken: got addr=%h redirect=%b want 0012 0", imem_addr, redirect); end
        br_cond = 1'b1;
        #1;
        checks++; if (inst_valid !== DS_IV) begin errors++; $display("FAIL taken_ack_iv: got %b want %b", inst_valid, DS_IV); end
        step();
        checks++; if (imem_addr !== 16'h0008 || redirect !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: got addr=%h redirect=%b req=%b iv=%b want 0008 1 0 0", imem_addr, redirect, imem_req, inst_valid);
        end
        checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL cond_no_link: got %b want 0", link_valid); end
        step();
        br_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 16'h0008 || redirect !== 1'b0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL after_flush: got addr=%h redirect=%b req=%b want 0008 0 1", imem_addr, redirect, imem_req);
        end
        step();
        checks++; if (imem_addr !== 16'h000A) begin errors++; $display("FAIL target_advance: got %h want 000A", imem_addr); end
    endtask

    task automatic test_wrap_jal();
        imem_ack = 1'b0;
        br_valid = 1'b1; br_kind = 2'b11; br_base_pc = 16'hFFFE; br_offset = 16'h0002;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jal_no_ack_iv: got %b want 0", inst_valid); end
        step();
        checks++; if (imem_addr !== 16'h0002 || redirect !== 1'b1) begin errors++; $display("FAIL jal_wrap: got addr=%h redirect=%b want 0002 1", imem_addr, redirect); end
        checks++; if (link_valid !== 1'b1 || link_addr !== 16'h0000) begin errors++; $display("FAIL jal_link: got lv=%b la=%h want 1 0000", link_valid, link_addr); end
        br_valid = 1'b0;
        step();
        checks++; if (link_valid !== 1'b0 || redirect !== 1'b0 || link_addr !== 16'h0000) begin
            errors++; $display("FAIL jal_pulse_width: got lv=%b redirect=%b la=%h want 0 0 0000", link_valid, redirect, link_addr);
        end
    endtask

    task automatic test_jump_reg();
        br_valid = 1'b1; br_kind = 2'b10; br_reg = 16'h1235; br_base_pc = 16'h0040; br_offset = 16'h0100;
        step();
        checks++; if (imem_addr !== 16'h1234 || redirect !== 1'b1 || link_valid !== 1'b0) begin
            errors++; $display("FAIL jump_reg: got addr=%h redirect=%b lv=%b want 1234 1 0", imem_addr, redirect, link_valid);
        end
        br_valid = 1'b0;
        step();
    endtask

    task automatic test_stall_priority();
        imem_ack = 1'b1; stall = 1'b1;
        br_valid = 1'b1; br_kind = 2'b01; br_base_pc = 16'h0100; br_offset = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_iv[%0d]: got %b want 0", i, inst_valid); end
            step();
            checks++; if (imem_addr !== 16'h1234 || redirect !== 1'b0 || imem_req !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: got addr=%h redirect=%b req=%b want 1234 0 1", i, imem_addr, redirect, imem_req);
            end
        end
        stall = 1'b0;
        #1;
        checks++; if (inst_valid !== DS_IV) begin errors++; $display("FAIL unstall_taken_iv: got %b want %b", inst_valid, DS_IV); end
        step();
        checks++; if (imem_addr !== 16'h0120 || redirect !== 1'b1) begin errors++; $display("FAIL unstall_redirect: got addr=%h redirect=%b want 0120 1", imem_addr, redirect); end
        br_valid = 1'b0;
    endtask

    task automatic test_reset_in_flush();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (imem_addr !== 16'h0000 || redirect !== 1'b0 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL reset_in_flush: got addr=%h redirect=%b req=%b iv=%b want 0000 0 0 0", imem_addr, redirect, imem_req, inst_valid);
        end
        step();
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reboot_boot: got req=%b want 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL reboot_fetch: got req=%b addr=%h want 1 0000", imem_req, imem_addr); end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        br_valid = 1'b0; br_kind = 2'b00; br_cond = 1'b0;
        br_base_pc = 16'h0000; br_offset = 16'h0000; br_reg = 16'h0000;
        test_reset();
        test_seq_fetch();
        test_branch_backward();
        test_wrap_jal();
        test_jump_reg();
        test_stall_priority();
        test_reset_in_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
